// File: rtl/motor_ramp_sequencer.sv
// Host-command sequencer for pwmc: tick-paced duty ramps, safe reversal, brake/estop.
// Optional command watchdog enabled by defining WATCHDOG_EN.
module motor_ramp_sequencer #(
    parameter logic [7:0] PERIOD      = 8'd200,
    parameter int         TICK_DIV    = 50000,
    parameter int         RAMP_STEP   = 1,
    parameter int         DWELL_TICKS = 20,
    parameter int         WDOG_TICKS  = 500
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_speed,
    input  logic       cmd_dir,
    input  logic       cmd_brake,
    input  logic       estop,
    output logic [7:0] dutyCycle,
    output logic [7:0] period,
    output logic       direction,
    output logic       pwmOutEnable,
    output logic       brake,
    output logic       busy,
    output logic       at_speed,
    output logic       fault
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DWELL_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP,
        S_HOLD,
        S_REVERSE,
        S_DWELL,
        S_BRAKE
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      duty_q, duty_d;
    logic            dir_q, dir_d;
    logic [7:0]      tgt_speed_q, tgt_speed_d;
    logic            tgt_dir_q, tgt_dir_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [DW-1:0]   dwell_q, dwell_d;

    logic            tick;
    logic            accept;
    logic [7:0]      cmd_clamped;
    logic [7:0]      nt_speed;
    logic            nt_dir;

    function automatic logic [7:0] step_to(input logic [7:0] cur,
                                           input logic [7:0] goal);
        int c;
        int g;
        c = int'(cur);
        g = int'(goal);
        if (g - c > RAMP_STEP) return 8'(c + RAMP_STEP);
        if (c - g > RAMP_STEP) return 8'(c - RAMP_STEP);
        return goal;
    endfunction

    assign cmd_ready    = (state_q != S_DWELL) && !estop;
    assign accept       = cmd_valid && cmd_ready;
    assign cmd_clamped  = (cmd_speed > PERIOD) ? PERIOD : cmd_speed;
    assign nt_speed     = accept ? cmd_clamped : tgt_speed_q;
    assign nt_dir       = accept ? cmd_dir : tgt_dir_q;
    assign tick         = (presc_q == PW'(TICK_DIV - 1));

    assign dutyCycle    = duty_q;
    assign period       = PERIOD;
    assign direction    = dir_q;
    assign pwmOutEnable = (state_q != S_IDLE);
    assign brake        = (state_q == S_BRAKE);
    assign busy         = (state_q != S_IDLE) && (state_q != S_HOLD);
    assign at_speed     = (state_q == S_HOLD);

`ifdef WATCHDOG_EN
    localparam int WW = $clog2(WDOG_TICKS + 1);
    logic [WW-1:0] wdog_q, wdog_d;
    logic          fault_q, fault_d;
    assign fault = fault_q;
`else
    logic wdog_unused;
    assign wdog_unused = (WDOG_TICKS > 0);
    assign fault       = 1'b0;
`endif

    always_comb begin
        presc_d     = tick ? '0 : presc_q + 1'b1;
        state_d     = state_q;
        duty_d      = duty_q;
        dir_d       = dir_q;
        dwell_d     = dwell_q;
        tgt_speed_d = nt_speed;
        tgt_dir_d   = nt_dir;
`ifdef WATCHDOG_EN
        wdog_d      = wdog_q;
        fault_d     = fault_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                duty_d = 8'd0;
                if (accept && nt_speed != 8'd0) begin
                    dir_d   = nt_dir;
                    state_d = S_RAMP;
                end
            end
            S_RAMP, S_HOLD: begin
                // HOLD shares the ramp rules, it just never steps
                if (state_q == S_RAMP && tick)
                    duty_d = step_to(duty_q, tgt_speed_q);
                if (nt_dir != dir_q) begin
                    if (duty_d != 8'd0) begin
                        state_d = S_REVERSE;
                    end else begin
                        dir_d   = nt_dir;
                        state_d = S_RAMP;
                    end
                end else if (duty_d == nt_speed) begin
                    state_d = (nt_speed == 8'd0) ? S_IDLE : S_HOLD;
                end else begin
                    state_d = S_RAMP;
                end
            end
            S_REVERSE: begin
                if (tick)
                    duty_d = step_to(duty_q, 8'd0);
                if (accept && nt_dir == dir_q) begin
                    state_d = S_RAMP;
                end else if (duty_d == 8'd0) begin
                    state_d = S_DWELL;
                    dwell_d = DW'(DWELL_TICKS);
                end
            end
            S_DWELL: begin
                duty_d = 8'd0;
                if (tick) begin
                    dwell_d = dwell_q - 1'b1;
                    if (dwell_q <= DW'(1)) begin
                        dir_d   = tgt_dir_q;
                        state_d = (tgt_speed_q != 8'd0) ? S_RAMP : S_IDLE;
                    end
                end
            end
            S_BRAKE: begin
                duty_d = 8'd0;
                if (accept) begin
                    dir_d   = nt_dir;
                    state_d = (nt_speed != 8'd0) ? S_RAMP : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                duty_d  = 8'd0;
            end
        endcase

        if (accept && cmd_brake) begin
            state_d = S_BRAKE;
            duty_d  = 8'd0;
            dir_d   = dir_q;
            dwell_d = dwell_q;
        end

`ifdef WATCHDOG_EN
        if (accept) begin
            wdog_d  = '0;
            fault_d = 1'b0;
        end else if (tick && (state_q == S_RAMP || state_q == S_HOLD ||
                              state_q == S_REVERSE || state_q == S_DWELL)) begin
            wdog_d = wdog_q + 1'b1;
            if (wdog_q == WW'(WDOG_TICKS - 1)) begin
                wdog_d  = '0;
                fault_d = 1'b1;
                state_d = S_BRAKE;
                duty_d  = 8'd0;
                dir_d   = dir_q;
            end
        end
`endif

        // estop beats commands and the watchdog alike
        if (estop) begin
            state_d = S_BRAKE;
            duty_d  = 8'd0;
            dir_d   = dir_q;
            dwell_d = dwell_q;
`ifdef WATCHDOG_EN
            fault_d = fault_q;
`endif
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            duty_q      <= 8'd0;
            dir_q       <= 1'b0;
            tgt_speed_q <= 8'd0;
            tgt_dir_q   <= 1'b0;
            presc_q     <= '0;
            dwell_q     <= '0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            dir_q       <= dir_d;
            tgt_speed_q <= tgt_speed_d;
            tgt_dir_q   <= tgt_dir_d;
            presc_q     <= presc_d;
            dwell_q     <= dwell_d;
        end
    end

`ifdef WATCHDOG_EN
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            wdog_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            fault_q <= fault_d;
        end
    end
`endif

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed bench for motor_ramp_sequencer (TICK_DIV=4, RAMP_STEP=10/30, DWELL=3).
// Define WATCHDOG_EN to also exercise the watchdog instance.
module tb_motor_ramp_sequencer;

    logic       clk_50 = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_speed = 8'd0;
    logic       cmd_dir = 1'b0;
    logic       cmd_brake = 1'b0;
    logic       estop = 1'b0;

    logic       cmd_ready, direction, pwmOutEnable, brake;
    logic       busy, at_speed, fault;
    logic [7:0] dutyCycle, period;

    logic       r2, d2, en2, b2, bz2, at2, f2;
    logic [7:0] duty2, per2;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk_50 = ~clk_50;

    motor_ramp_sequencer #(
        .PERIOD(8'd200), .TICK_DIV(4), .RAMP_STEP(10), .DWELL_TICKS(3)
    ) u_dut (
        .clk_50(clk_50), .reset_n(reset_n), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_speed(cmd_speed), .cmd_dir(cmd_dir),
        .cmd_brake(cmd_brake), .estop(estop), .dutyCycle(dutyCycle),
        .period(period), .direction(direction), .pwmOutEnable(pwmOutEnable),
        .brake(brake), .busy(busy), .at_speed(at_speed), .fault(fault)
    );

    motor_ramp_sequencer #(
        .PERIOD(8'd200), .TICK_DIV(4), .RAMP_STEP(30), .DWELL_TICKS(3)
    ) u_dut30 (
        .clk_50(clk_50), .reset_n(reset_n), .cmd_valid(cmd_valid),
        .cmd_ready(r2), .cmd_speed(cmd_speed), .cmd_dir(cmd_dir),
        .cmd_brake(cmd_brake), .estop(estop), .dutyCycle(duty2),
        .period(per2), .direction(d2), .pwmOutEnable(en2),
        .brake(b2), .busy(bz2), .at_speed(at2), .fault(f2)
    );

`ifdef WATCHDOG_EN
    logic       wr, wd, wen, wb, wbz, wat, wf;
    logic [7:0] wduty, wper;
    motor_ramp_sequencer #(
        .PERIOD(8'd200), .TICK_DIV(4), .RAMP_STEP(10), .DWELL_TICKS(3),
        .WDOG_TICKS(5)
    ) u_wd (
        .clk_50(clk_50), .reset_n(reset_n), .cmd_valid(cmd_valid),
        .cmd_ready(wr), .cmd_speed(cmd_speed), .cmd_dir(cmd_dir),
        .cmd_brake(cmd_brake), .estop(estop), .dutyCycle(wduty),
        .period(wper), .direction(wd), .pwmOutEnable(wen),
        .brake(wb), .busy(wbz), .at_speed(wat), .fault(wf)
    );
`endif

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_50);
    endtask

    task automatic send(input logic [7:0] s, input logic d, input logic b);
        int n;
        n = 0;
        cmd_speed = s;
        cmd_dir   = d;
        cmd_brake = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 60) begin
            @(negedge clk_50);
            n++;
        end
        check_eq("send_ready", int'(cmd_ready), 1);
        @(negedge clk_50);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_dc(output int gap);
        logic [7:0] prev;
        prev = dutyCycle;
        gap = 0;
        while (dutyCycle == prev && gap < 20) begin
            @(negedge clk_50);
            gap++;
        end
    endtask

    task automatic wait_at(input int limit);
        int n;
        n = 0;
        while (!at_speed && n < limit) begin
            @(negedge clk_50);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int gap;
        int n;
        logic pd;

        // 1: reset state and ramp up to 100 clockwise
        cyc(2);
        check_eq("rst_duty", dutyCycle, 0);
        check_eq("rst_period", period, 200);
        check_eq("rst_dir", direction, 0);
        check_eq("rst_en", pwmOutEnable, 0);
        check_eq("rst_brake", brake, 0);
        check_eq("rst_ready", cmd_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_at", at_speed, 0);
        check_eq("rst_fault", fault, 0);
        reset_n = 1'b1;
        cyc(3);
        send(8'd100, 1'b1, 1'b0);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_en", pwmOutEnable, 1);
        check_eq("t1_dir", direction, 1);
        for (int k = 1; k <= 10; k++) begin
            wait_dc(gap);
            check_eq($sformatf("t1_duty%0d", k), dutyCycle, 10 * k);
            if (k > 1) check_eq($sformatf("t1_gap%0d", k), gap, 4);
            if (k <= 4)
                check_eq($sformatf("t1_s30_%0d", k), duty2,
                         (30 * k > 100) ? 100 : 30 * k);
        end
        cyc(1);
        check_eq("t1_at", at_speed, 1);
        check_eq("t1_busy0", busy, 0);
        check_eq("t1_dir1", direction, 1);
        check_eq("t1_s30_at", at2, 1);

        // 2: reversal through zero and dwell
        send(8'd50, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            wait_dc(gap);
            check_eq($sformatf("t2_dn%0d", k), dutyCycle, 100 - 10 * k);
            check_eq($sformatf("t2_dir%0d", k), direction, 1);
        end
        check_eq("t2_dwell_ready", cmd_ready, 0);
        check_eq("t2_dwell_en", pwmOutEnable, 1);
        check_eq("t2_dwell_busy", busy, 1);
        pd = direction;
        gap = 0;
        while (direction == pd && gap < 40) begin
            @(negedge clk_50);
            gap++;
        end
        check_eq("t2_dwell_len", gap, 12);
        check_eq("t2_newdir", direction, 0);
        check_eq("t2_ready_back", cmd_ready, 1);
        for (int k = 1; k <= 5; k++) begin
            wait_dc(gap);
            check_eq($sformatf("t2_up%0d", k), dutyCycle, 10 * k);
            if (k == 1) check_eq("t2_first_gap", gap, 4);
        end
        cyc(1);
        check_eq("t2_at", at_speed, 1);
        check_eq("t2_s30_duty", duty2, 50);
        check_eq("t2_s30_dir", d2, 0);

        // 3: estop mid-ramp
        send(8'd150, 1'b0, 1'b0);
        wait_dc(gap);
        check_eq("t3_r1", dutyCycle, 60);
        wait_dc(gap);
        check_eq("t3_r2", dutyCycle, 70);
        estop = 1'b1;
        cyc(1);
        check_eq("t3_brake", brake, 1);
        check_eq("t3_duty0", dutyCycle, 0);
        check_eq("t3_en", pwmOutEnable, 1);
        check_eq("t3_ready0", cmd_ready, 0);
        cmd_speed = 8'd80;
        cmd_brake = 1'b0;
        cmd_valid = 1'b1;
        cyc(3);
        check_eq("t3_refused", brake, 1);
        check_eq("t3_refused_duty", dutyCycle, 0);
        estop = 1'b0;
        cmd_valid = 1'b0;
        cyc(3);
        check_eq("t3_stay_brake", brake, 1);
        check_eq("t3_busy", busy, 1);
        send(8'd20, 1'b0, 1'b0);
        check_eq("t3_unbrake", brake, 0);
        wait_dc(gap);
        check_eq("t3_u1", dutyCycle, 10);
        wait_dc(gap);
        check_eq("t3_u2", dutyCycle, 20);
        cyc(1);
        check_eq("t3_at", at_speed, 1);

        // 4: speed clamp to PERIOD, then brake command
        send(8'd255, 1'b0, 1'b0);
        wait_at(300);
        check_eq("t4_sat", dutyCycle, 200);
        check_eq("t4_at", at_speed, 1);
        check_eq("t4_s30_sat", duty2, 200);
        send(8'd0, 1'b0, 1'b1);
        check_eq("t4_brake", brake, 1);
        check_eq("t4_brake_duty", dutyCycle, 0);
        check_eq("t4_s30_brake", b2, 1);

        // 5: async reset mid-ramp
        send(8'd100, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) wait_dc(gap);
        check_eq("t5_pre", dutyCycle, 30);
        #3 reset_n = 1'b0;
        #1;
        check_eq("t5_duty", dutyCycle, 0);
        check_eq("t5_dir", direction, 0);
        check_eq("t5_en", pwmOutEnable, 0);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_ready", cmd_ready, 1);
        check_eq("t5_s30_duty", duty2, 0);
        @(negedge clk_50);
        reset_n = 1'b1;
        cyc(2);
        send(8'd40, 1'b1, 1'b0);
        wait_at(100);
        check_eq("t5_rec_duty", dutyCycle, 40);
        check_eq("t5_rec_dir", direction, 1);

        // 6: no watchdog on the main instance: HOLD persists
        cyc(40);
        check_eq("t6_hold", at_speed, 1);
        check_eq("t6_duty", dutyCycle, 40);
        check_eq("t6_fault", fault, 0);
`ifdef WATCHDOG_EN
        n = 0;
        while (!wf && n < 200) begin
            @(negedge clk_50);
            n++;
        end
        check_eq("t6_wd_fault", wf, 1);
        check_eq("t6_wd_brake", wb, 1);
        send(8'd0, 1'b1, 1'b0);
        check_eq("t6_wd_clear", wf, 0);
`else
        n = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
